// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - raster timing generator: hs/vs/de, counters, 8x16 cell addressing
// Optional VGA_TIMING_DELAY_EN: hs_d/vs_d/de_d via a PIPE_DELAY-deep register chain.
module vga_timing #(
    parameter int RES_H      = 640,
    parameter int FP_H       = 16,
    parameter int SYNC_H     = 96,
    parameter int BP_H       = 48,
    parameter int NEG_H      = 1,
    parameter int RES_V      = 480,
    parameter int FP_V       = 10,
    parameter int SYNC_V     = 2,
    parameter int BP_V       = 33,
    parameter int NEG_V      = 1,
    parameter int PIPE_DELAY = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [11:0] h_count,
    output logic [11:0] v_count,
    output logic        line_start,
    output logic        frame_start,
    output logic [6:0]  char_col,
    output logic [2:0]  glyph_x,
    output logic [5:0]  char_row,
    output logic [3:0]  glyph_y,
    output logic        hs_d,
    output logic        vs_d,
    output logic        de_d
);

    localparam logic [11:0] H_TOTAL = 12'(RES_H + FP_H + SYNC_H + BP_H);
    localparam logic [11:0] H_ACT   = 12'(RES_H);
    localparam logic [11:0] HS_BEG  = 12'(RES_H + FP_H);
    localparam logic [11:0] HS_END  = 12'(RES_H + FP_H + SYNC_H);
    localparam logic [11:0] V_TOTAL = 12'(RES_V + FP_V + SYNC_V + BP_V);
    localparam logic [11:0] V_ACT   = 12'(RES_V);
    localparam logic [11:0] VS_BEG  = 12'(RES_V + FP_V);
    localparam logic [11:0] VS_END  = 12'(RES_V + FP_V + SYNC_V);
    localparam logic        POL_H   = (NEG_H != 0);
    localparam logic        POL_V   = (NEG_V != 0);

`ifdef VGA_TIMING_DELAY_EN
    localparam int DLY_EN = 1;
`else
    localparam int DLY_EN = 0;
`endif
    localparam int DLY = DLY_EN * PIPE_DELAY;

    logic [11:0] r_h, r_v;
    logic        r_hs, r_vs, r_de, r_ls, r_fs;
    logic [11:0] w_h_nxt, w_v_nxt;
    logic        w_hs_nxt, w_vs_nxt, w_de_nxt, w_ls_nxt, w_fs_nxt;

    // Flags are decoded from the next count so they land in the same cycle as it.
    always_comb begin
        w_h_nxt = r_h + 12'd1;
        w_v_nxt = r_v;
        if (r_h == H_TOTAL - 12'd1) begin
            w_h_nxt = 12'd0;
            w_v_nxt = (r_v == V_TOTAL - 12'd1) ? 12'd0 : r_v + 12'd1;
        end
        w_de_nxt = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
        w_hs_nxt = ((w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END)) ^ POL_H;
        w_vs_nxt = ((w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END)) ^ POL_V;
        w_ls_nxt = (w_h_nxt == 12'd0) && (w_v_nxt < V_ACT);
        w_fs_nxt = (w_h_nxt == 12'd0) && (w_v_nxt == 12'd0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_h  <= H_TOTAL - 12'd1;
            r_v  <= V_TOTAL - 12'd1;
            r_de <= 1'b0;
            r_hs <= POL_H;
            r_vs <= POL_V;
            r_ls <= 1'b0;
            r_fs <= 1'b0;
        end else begin
            r_h  <= w_h_nxt;
            r_v  <= w_v_nxt;
            r_de <= w_de_nxt;
            r_hs <= w_hs_nxt;
            r_vs <= w_vs_nxt;
            r_ls <= w_ls_nxt;
            r_fs <= w_fs_nxt;
        end
    end

    assign hs          = r_hs;
    assign vs          = r_vs;
    assign de          = r_de;
    assign h_count     = r_h;
    assign v_count     = r_v;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
    assign char_col    = r_h[9:3];
    assign glyph_x     = r_h[2:0];
    assign char_row    = r_v[9:4];
    assign glyph_y     = r_v[3:0];

    generate
        if (DLY == 0) begin : g_direct
            assign hs_d = r_hs;
            assign vs_d = r_vs;
            assign de_d = r_de;
        end else begin : g_pipe
            logic [2:0] r_pipe [DLY];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DLY; i++) r_pipe[i] <= {POL_H, POL_V, 1'b0};
                end else begin
                    r_pipe[0] <= {r_hs, r_vs, r_de};
                    for (int i = 1; i < DLY; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign {hs_d, vs_d, de_d} = r_pipe[DLY-1];
        end
    endgenerate

endmodule
